// File: rtl/result_drain_pkg.sv
// Shared definitions for the result SRAM drain path: FSM state encoding,
// default geometry and width helpers derived from the lane count and lane width.
package result_drain_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int DEF_ADDRESSSIZE    = 10;
  localparam int DEF_MATRIX_SIZE    = 32;
  localparam int DEF_PARTIAL_SUM_BW = 24;

  // Width of one full result word (all lanes side by side).
  function automatic int word_width(input int lanes, input int lane_bits);
    return lanes * lane_bits;
  endfunction

  // Width of a counter that indexes every lane of a word.
  function automatic int lane_cnt_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/result_drain_word_serializer.sv
// result_word_serializer: parallel-loads one result word and shifts it out
// lane by lane (lane 0 first) on each accepted handshake. The lane counter
// is control and is reset; the word register is data and is not.
module result_word_serializer
  import result_drain_pkg::*;
#(
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    load,
  input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]   load_data,
  input  logic                                    shift,
  output logic signed [PARTIAL_SUM_BW-1:0]        lane_data,
  output logic                                    last_lane
);

  localparam int WORD_W = word_width(MATRIX_SIZE, PARTIAL_SUM_BW);
  localparam int CNT_W  = lane_cnt_width(MATRIX_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WORD_W-1:0] word_p0;
  logic [CNT_W-1:0]  lane_cnt;

  // Stage p0: word register, loaded whole and shifted down one lane per accept.
  always_ff @(posedge clk) begin
    if (load) begin
      word_p0 <= load_data;
    end else if (shift) begin
      word_p0 <= word_p0 >> PARTIAL_SUM_BW;
    end
  end

  // Lane counter tracks which lane of the word is currently at the bottom.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_cnt <= '0;
    end else if (load) begin
      lane_cnt <= '0;
    end else if (shift) begin
      lane_cnt <= lane_cnt + CNT_ONE;
    end
  end

  assign lane_data = word_p0[PARTIAL_SUM_BW-1:0];
  assign last_lane = (lane_cnt == LAST_IDX);

endmodule

// File: rtl/result_drain.sv
// result_drain: reads finished result words from the result SRAM and streams
// them out lane by lane over a valid/ready interface, flagging the last lane
// of the last word and pulsing done at the end of each drain.
// Optional build macro RESULT_DRAIN_RELU_EN clamps negative lanes to zero at
// the output mux; timing and handshake are the same in both builds.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [ADDRESSSIZE:0]                  num_words,
  output logic [ADDRESSSIZE-1:0]                rd_addr,
  output logic                                  rd_en,
  input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] rd_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [PARTIAL_SUM_BW-1:0]      out_data,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam logic [ADDRESSSIZE-1:0] ADDR_ONE  = ADDRESSSIZE'(1);
  localparam logic [ADDRESSSIZE:0]   WORDS_ONE = (ADDRESSSIZE + 1)'(1);

  state_t                           state;
  state_t                           state_nxt;
  logic [ADDRESSSIZE:0]             words_left;
  logic                             handshake;
  logic signed [PARTIAL_SUM_BW-1:0] lane;
  logic                             last_lane;

  // Output lane conditioning: optional clamp of negative lanes to zero.
  function automatic logic signed [PARTIAL_SUM_BW-1:0] relu_lane(
    input logic signed [PARTIAL_SUM_BW-1:0] v
  );
`ifdef RESULT_DRAIN_RELU_EN
    return v[PARTIAL_SUM_BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign handshake = out_valid & out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a zero-length request goes straight to FIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_words == '0) ? FIN : FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (handshake && last_lane) state_nxt = (words_left != '0) ? FETCH : FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and remaining-word counters: captured on start, stepped once per fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr    <= '0;
      words_left <= '0;
    end else if (state == IDLE && start) begin
      rd_addr    <= base_addr;
      words_left <= num_words;
    end else if (state == FETCH) begin
      rd_addr    <= rd_addr + ADDR_ONE;
      words_left <= words_left - WORDS_ONE;
    end
  end

  // SRAM data arrives during LOAD and is captured into the serializer there.
  result_word_serializer #(
    .MATRIX_SIZE    (MATRIX_SIZE),
    .PARTIAL_SUM_BW (PARTIAL_SUM_BW)
  ) u_serializer (
    .clk       (clk),
    .rstn      (rstn),
    .load      (state == LOAD),
    .load_data (rd_data),
    .shift     (handshake),
    .lane_data (lane),
    .last_lane (last_lane)
  );

  // Outputs decode registered state only; out_data is forced to zero outside SEND.
  assign rd_en     = (state == FETCH);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (words_left == '0) && last_lane;
  assign out_data  = out_valid ? relu_lane(lane) : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule
